// File: rtl/ldpc_pkg.sv
// Shared types and defaults for the layered LDPC iteration controller.
package ldpc_pkg;

    localparam int LDPC_L          = 32;
    localparam int LDPC_K          = 6;
    localparam int LDPC_NUM_LAYERS = 3;
    localparam int LDPC_ADDR_WIDTH = $clog2(LDPC_L);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CNU,
        ST_CNU_DRAIN,
        ST_CHECK,
        ST_VNU,
        ST_VNU_DRAIN,
        ST_READ,
        ST_DONE
    } ldpc_state_t;

    typedef struct packed {
        logic in_ready;
        logic cnu_en;
        logic vnu_en;
        logic rd_en;
        logic busy;
        logic done;
    } ldpc_ctrl_t;

    // Last index of a drain of `lat` cycles; zero-length drains are bypassed.
    function automatic int lat_last(input int lat);
        return (lat > 0) ? lat - 1 : 0;
    endfunction

endpackage

// File: rtl/ldpc_phase_counter.sv
// Mod-L address counter shared by the LOAD, CNU, VNU and READ phases.
module ldpc_phase_counter #(
    parameter int L          = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  en,
    output logic [ADDR_WIDTH-1:0] count,
    output logic                  tc
);

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == ADDR_WIDTH'(L - 1));

endmodule

// File: rtl/ldpc_iter_ctrl.sv
// Iteration controller for the layered LDPC decoder: load, CNU/VNU iterations, read-out.
// Define LDPC_EARLY_TERM_EN to let a zero syndrome end decoding early.
module ldpc_iter_ctrl
    import ldpc_pkg::*;
#(
    parameter int L          = LDPC_L,
    parameter int ADDR_WIDTH = LDPC_ADDR_WIDTH,
    parameter int K          = LDPC_K,
    parameter int NUM_LAYERS = LDPC_NUM_LAYERS,
    parameter int CNU_LAT    = 4,
    parameter int VNU_LAT    = 2,
    parameter int ITER_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ITER_WIDTH-1:0]   max_iter,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [ADDR_WIDTH-1:0]   load_add,
    output logic                    cnu_en,
    output logic                    vnu_en,
    output logic [ADDR_WIDTH-1:0]   proc_add,
    input  logic                    p_valid,
    input  logic [NUM_LAYERS*K-1:0] p_bit,
    output logic                    rd_en,
    output logic [ADDR_WIDTH-1:0]   rd_add,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    converged,
    output logic [ITER_WIDTH-1:0]   iter_used
);

    localparam int DRAIN_MAX = (CNU_LAT > VNU_LAT) ? CNU_LAT : VNU_LAT;
    localparam int DRAIN_W   = (DRAIN_MAX < 2) ? 1 : $clog2(DRAIN_MAX);

    ldpc_state_t           state, next_state, vnu_exit;
    ldpc_ctrl_t            ctrl_nxt, ctrl_q;
    logic [ITER_WIDTH-1:0] iter_limit;
    logic                  syndrome;
    logic [DRAIN_W-1:0]    drain_cnt;
    logic [ADDR_WIDTH-1:0] count;
    logic                  cnt_tc, cnt_en, cnt_clr;
    logic                  start_acc, p_window, p_hit, check_dirty;
    logic                  cnu_drain_last, vnu_drain_last;

    assign start_acc      = (state == ST_IDLE) && start;
    assign p_window       = (state == ST_CNU) || (state == ST_CNU_DRAIN) || (state == ST_CHECK);
    assign p_hit          = p_valid && (|p_bit);
    assign check_dirty    = syndrome || (p_window && p_hit);
    assign cnu_drain_last = (drain_cnt == DRAIN_W'(lat_last(CNU_LAT)));
    assign vnu_drain_last = (drain_cnt == DRAIN_W'(lat_last(VNU_LAT)));
    assign vnu_exit       = (iter_used >= iter_limit) ? ST_READ : ST_CNU;

    // Every phase starts its address sequence from zero.
    assign cnt_clr = (next_state != state);
    assign cnt_en  = (state == ST_LOAD) ? in_valid
                   : ((state == ST_CNU) || (state == ST_VNU) || (state == ST_READ));

    ldpc_phase_counter #(
        .L          (L),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_phase_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (count),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves next_state unassigned (no latch).
        next_state = state;
        case (state)
            ST_IDLE:      if (start) next_state = ST_LOAD;
            ST_LOAD:      if (in_valid && cnt_tc) next_state = ST_CNU;
            ST_CNU:       if (cnt_tc) next_state = (CNU_LAT == 0) ? ST_CHECK : ST_CNU_DRAIN;
            ST_CNU_DRAIN: if (cnu_drain_last) next_state = ST_CHECK;
            ST_CHECK: begin
`ifdef LDPC_EARLY_TERM_EN
                next_state = check_dirty ? ST_VNU : ST_READ;
`else
                next_state = ST_VNU;
`endif
            end
            ST_VNU:       if (cnt_tc) next_state = (VNU_LAT == 0) ? vnu_exit : ST_VNU_DRAIN;
            ST_VNU_DRAIN: if (vnu_drain_last) next_state = vnu_exit;
            ST_READ:      if (cnt_tc) next_state = ST_DONE;
            ST_DONE:      next_state = ST_IDLE;
            default:      next_state = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so the registered copy lines up with the state.
    always_comb begin
        ctrl_nxt          = '0;
        ctrl_nxt.in_ready = (next_state == ST_LOAD);
        ctrl_nxt.cnu_en   = (next_state == ST_CNU);
        ctrl_nxt.vnu_en   = (next_state == ST_VNU);
        ctrl_nxt.rd_en    = (next_state == ST_READ);
        ctrl_nxt.busy     = (next_state != ST_IDLE);
        ctrl_nxt.done     = (next_state == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q    <= '0;
            out_valid <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_nxt;
            out_valid <= ctrl_q.rd_en;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drain_cnt <= '0;
        end else if (next_state != state) begin
            drain_cnt <= '0;
        end else if ((state == ST_CNU_DRAIN) || (state == ST_VNU_DRAIN)) begin
            drain_cnt <= drain_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iter_limit <= '0;
            iter_used  <= '0;
            converged  <= 1'b0;
            syndrome   <= 1'b0;
        end else if (start_acc) begin
            iter_limit <= (max_iter == '0) ? ITER_WIDTH'(1) : max_iter;
            iter_used  <= '0;
            converged  <= 1'b0;
            syndrome   <= 1'b0;
        end else begin
            if ((next_state == ST_CNU) && (state != ST_CNU)) begin
                syndrome <= 1'b0;
            end else if (p_window && p_hit) begin
                syndrome <= 1'b1;
            end
            if (state == ST_CHECK) begin
                iter_used <= iter_used + 1'b1;
                converged <= ~check_dirty;
            end
        end
    end

    assign in_ready = ctrl_q.in_ready;
    assign cnu_en   = ctrl_q.cnu_en;
    assign vnu_en   = ctrl_q.vnu_en;
    assign rd_en    = ctrl_q.rd_en;
    assign busy     = ctrl_q.busy;
    assign done     = ctrl_q.done;
    assign load_add = count;
    assign proc_add = count;
    assign rd_add   = count;

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// Self-checking bench for ldpc_iter_ctrl; expectations follow LDPC_EARLY_TERM_EN if defined.
module tb_ldpc_iter_ctrl;

    localparam int L     = 8;
    localparam int AW    = 3;
    localparam int K     = 6;
    localparam int NL    = 3;
    localparam int CL    = 4;
    localparam int VL    = 2;
    localparam int IW    = 5;
    localparam int PW    = NL * K;
    localparam int OUTW  = 3 * AW + IW + 8;
    localparam int BOUND = 3000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [IW-1:0] max_iter = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] load_add;
    logic          cnu_en;
    logic          vnu_en;
    logic [AW-1:0] proc_add;
    logic          p_valid;
    logic [PW-1:0] p_bit;
    logic          rd_en;
    logic [AW-1:0] rd_add;
    logic          out_valid;
    logic          busy;
    logic          done;
    logic          converged;
    logic [IW-1:0] iter_used;
    logic [OUTW-1:0] all_out;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   drv_iter = 0;
    int   drv_clean_from = 99;
    logic drv_prev_cnu = 1'b0;

    assign all_out = {in_ready, load_add, cnu_en, vnu_en, proc_add, rd_en, rd_add,
                      out_valid, busy, done, converged, iter_used};

    ldpc_iter_ctrl #(
        .L          (L),
        .ADDR_WIDTH (AW),
        .K          (K),
        .NUM_LAYERS (NL),
        .CNU_LAT    (CL),
        .VNU_LAT    (VL),
        .ITER_WIDTH (IW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .max_iter  (max_iter),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .load_add  (load_add),
        .cnu_en    (cnu_en),
        .vnu_en    (vnu_en),
        .proc_add  (proc_add),
        .p_valid   (p_valid),
        .p_bit     (p_bit),
        .rd_en     (rd_en),
        .rd_add    (rd_add),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done),
        .converged (converged),
        .iter_used (iter_used)
    );

    always #5 clk = ~clk;

    // CNU writeback emulation: iterations before drv_clean_from carry a guaranteed
    // nonzero parity beat on their first CNU cycle; later iterations are all-zero.
    initial begin
        logic [PW-1:0] pb;
        p_valid = 1'b0;
        p_bit   = '0;
        forever begin
            @(negedge clk);
            if (cnu_en && !drv_prev_cnu) drv_iter++;
            if (drv_iter == 0 || drv_iter < drv_clean_from) begin
                pb = PW'($urandom);
                pb[$urandom_range(PW - 1, 0)] = 1'b1;
                p_bit   = pb;
                p_valid = (cnu_en && !drv_prev_cnu) ? 1'b1 : 1'($urandom_range(1, 0));
            end else begin
                p_bit   = '0;
                p_valid = 1'($urandom_range(1, 0));
            end
            drv_prev_cnu = cnu_en;
        end
    end

    task automatic run_decode(input int mi, input int clean_from, input bit stall,
                              input bit poke, input string tag);
        int lim, n, exp_vnu, exp_lat, load_cyc, cyc;
        int ld_cyc = 0, beats = 0, off = 0, roff = 0, n_cnu = 0, n_vnu = 0, done_cyc = 0;
        int ld_err = 0, proc_err = 0, rd_err = 0, ov_err = 0, busy_err = 0;
        bit early = 0, exited = 0, exp_conv, seen_done = 0, poked = 0;
        bit prev_rd = 0, prev_cnu = 0, prev_vnu = 0;

        // Reference model from the decode rules.
        lim = (mi == 0) ? 1 : mi;
`ifdef LDPC_EARLY_TERM_EN
        early = 1;
`endif
        n = lim;
        if (early) begin
            for (int i = 1; i <= lim; i++) begin
                if (i >= clean_from) begin
                    n = i;
                    exited = 1;
                    break;
                end
            end
        end
        exp_conv = (n >= clean_from);
        exp_vnu  = exited ? n - 1 : n;
        load_cyc = stall ? 2 * L : L;
        exp_lat  = 1 + load_cyc + n * (L + CL + 1 + L + VL) - (exited ? L + VL : 0) + L + 1;

        drv_clean_from = clean_from;
        drv_iter = 0;
        max_iter = IW'(mi);
        start    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        start    = 1'b0;
        max_iter = IW'($urandom);
        cyc = 2;
        while (cyc < BOUND) begin
            if (in_ready) begin
                ld_cyc++;
                if (load_add !== AW'(beats)) ld_err++;
            end
            if (cnu_en && !prev_cnu) n_cnu++;
            if (vnu_en && !prev_vnu) n_vnu++;
            if (cnu_en || vnu_en) begin
                if (proc_add !== AW'(off)) proc_err++;
                off++;
            end else begin
                off = 0;
            end
            if (rd_en) begin
                if (rd_add !== AW'(roff)) rd_err++;
                roff++;
            end
            if (out_valid !== prev_rd) ov_err++;
            if (busy !== 1'b1) busy_err++;
            prev_rd  = rd_en;
            prev_cnu = cnu_en;
            prev_vnu = vnu_en;
            if (done === 1'b1) begin
                seen_done = 1;
                done_cyc  = cyc;
                if (out_valid !== 1'b1) ov_err++;
                break;
            end
            if (in_ready) in_valid = stall ? (ld_cyc % 2 == 0) : 1'b1;
            else          in_valid = 1'($urandom_range(1, 0));
            if (in_ready && in_valid) beats++;
            start = 1'b0;
            if (poke && !poked && cnu_en) begin
                start    = 1'b1;
                max_iter = IW'(7);
                poked    = 1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;

        n_checks++;
        if (!seen_done) begin
            n_fail++;
            $display("FAIL %s timeout: no done within %0d cycles", tag, BOUND);
        end
        n_checks++;
        if (done_cyc != exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", tag, done_cyc, exp_lat);
        end
        n_checks++;
        if (iter_used !== IW'(n)) begin
            n_fail++;
            $display("FAIL %s iter_used: got %0d expected %0d", tag, iter_used, n);
        end
        n_checks++;
        if (converged !== exp_conv) begin
            n_fail++;
            $display("FAIL %s converged: got %b expected %b", tag, converged, exp_conv);
        end
        n_checks++;
        if (n_vnu != exp_vnu || n_cnu != n) begin
            n_fail++;
            $display("FAIL %s phases: cnu %0d vnu %0d expected cnu %0d vnu %0d",
                     tag, n_cnu, n_vnu, n, exp_vnu);
        end
        n_checks++;
        if (ld_cyc != load_cyc || beats != L || ld_err != 0) begin
            n_fail++;
            $display("FAIL %s load: cycles %0d beats %0d addr_err %0d expected cycles %0d beats %0d addr_err 0",
                     tag, ld_cyc, beats, ld_err, load_cyc, L);
        end
        n_checks++;
        if (proc_err != 0) begin
            n_fail++;
            $display("FAIL %s proc_add: %0d wrong addresses expected 0", tag, proc_err);
        end
        n_checks++;
        if (rd_err != 0 || roff != L || ov_err != 0) begin
            n_fail++;
            $display("FAIL %s read: rd_addr_err %0d rd_beats %0d out_valid_err %0d expected 0 %0d 0",
                     tag, rd_err, roff, ov_err, L);
        end
        n_checks++;
        if (busy_err != 0) begin
            n_fail++;
            $display("FAIL %s busy: dropped %0d times expected 0", tag, busy_err);
        end

        in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_done: done %b busy %b out_valid %b expected 0 0 0",
                     tag, done, busy, out_valid);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_state: outputs %h expected 0", all_out);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy %b in_ready %b expected 0 0", busy, in_ready);
        end
    endtask

    task automatic test_fixed_iter;
        run_decode(3, 99, 0, 0, "fixed_iter");
    endtask

    task automatic test_early_term;
        run_decode(5, 2, 0, 0, "early_term");
    endtask

    task automatic test_load_stall;
        run_decode(2, 99, 1, 0, "load_stall");
    endtask

    task automatic test_zero_iter;
        run_decode(0, 99, 0, 1, "zero_iter");
    endtask

    task automatic test_reset_mid_vnu;
        bit found = 0;
        int bad = 0;
        drv_clean_from = 99;
        drv_iter = 0;
        max_iter = IW'(3);
        start    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < BOUND; c++) begin
            if (vnu_en === 1'b1 && proc_add === AW'(3)) begin
                found = 1;
                break;
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL reset_mid_vnu reach: VNU address 3 not seen within %0d cycles", BOUND);
        end
        #2 reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_vnu outputs: %h expected 0", all_out);
        end
        reset = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_mid_vnu idle: %0d cycles with done or busy set expected 0", bad);
        end
        run_decode(2, 99, 0, 0, "after_reset");
    endtask

    task automatic test_random;
        for (int r = 0; r < 4; r++) begin
            run_decode(int'($urandom_range(6, 0)), int'($urandom_range(8, 1)),
                       1'($urandom_range(1, 0)), 0, $sformatf("random%0d", r));
        end
    endtask

    task automatic test_back_to_back;
        run_decode(1, 1, 0, 0, "b2b_a");
        run_decode(4, 3, 1, 0, "b2b_b");
    endtask

    initial begin
        test_reset();
        test_fixed_iter();
        test_early_term();
        test_load_stall();
        test_zero_iter();
        test_reset_mid_vnu();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
